// File: rtl/dec_scoreboard.sv
// Register scoreboard: one-hot decoders set a pending bit on issue and clear it on writeback;
// query ports report busy sources for the decode-stage stall.
module dec_scoreboard #(
   parameter int ADDR_W   = 5,
   parameter int RD_PORTS = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         iss_valid,
   input  logic [ADDR_W-1:0]            iss_addr,
   output logic                         iss_ready,
   input  logic                         wb_valid,
   input  logic [ADDR_W-1:0]            wb_addr,
   input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
   output logic [RD_PORTS-1:0]          rd_busy,
   output logic [(2**ADDR_W)-1:0]       pend,
   output logic [ADDR_W:0]              pend_cnt,
   output logic                         err_wb
);

   localparam int NREG = 2**ADDR_W;

   logic [NREG-1:0] pend_q, pend_d;
   logic [NREG-1:0] iss_dec, wb_dec;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            iss_zero, wb_zero, wb_hits_iss;

   always_comb begin
      // NOTE: every signal gets a default before any conditional write, so no latch is inferred.
      iss_dec     = '0;
      wb_dec      = '0;
      iss_zero    = ZERO_REG && (iss_addr == '0);
      wb_zero     = ZERO_REG && (wb_addr == '0);
      wb_hits_iss = wb_valid && (wb_addr == iss_addr);

      // A second writer to a pending register waits unless that register retires now.
      iss_ready = !flush && (!pend_q[iss_addr] || wb_hits_iss || iss_zero);

      if (iss_valid && iss_ready && !iss_zero)
         iss_dec[iss_addr] = 1'b1;
      if (wb_valid && !wb_zero)
         wb_dec[wb_addr] = 1'b1;

      // Set after clear: a same-cycle reissue of a retiring register stays pending.
      pend_d = flush ? '0 : ((pend_q & ~wb_dec) | iss_dec);

      cnt_d = '0;
      for (int i = 0; i < NREG; i++)
         cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};

      err_d = wb_valid && !pend_q[wb_addr] && !flush && !wb_zero;
   end

   // Same-cycle writeback counts as forwarded, so it never stalls a reader.
   for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      assign a          = rd_addr[k*ADDR_W +: ADDR_W];
      assign rd_busy[k] = pend_q[a] && !(wb_valid && (wb_addr == a))
                          && !(ZERO_REG && (a == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign pend     = pend_q;
   assign pend_cnt = cnt_q;
   assign err_wb   = err_q;

endmodule

// File: tb/tb_dec_scoreboard.sv
// Bench for dec_scoreboard: directed scenarios on a 32-register and an 8-register instance,
// then randomized traffic checked against a set-based reference model.
module tb_dec_scoreboard;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // 32-register, 2-port instance
   logic        a_flush, a_iss_valid, a_iss_ready, a_wb_valid, a_err_wb;
   logic [4:0]  a_iss_addr, a_wb_addr;
   logic [9:0]  a_rd_addr;
   logic [1:0]  a_rd_busy;
   logic [31:0] a_pend;
   logic [5:0]  a_pend_cnt;

   // 8-register, 3-port instance
   logic        b_flush, b_iss_valid, b_iss_ready, b_wb_valid, b_err_wb;
   logic [2:0]  b_iss_addr, b_wb_addr;
   logic [8:0]  b_rd_addr;
   logic [2:0]  b_rd_busy;
   logic [7:0]  b_pend;
   logic [3:0]  b_pend_cnt;

   dec_scoreboard #(.ADDR_W(5), .RD_PORTS(2), .ZERO_REG(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush),
      .iss_valid(a_iss_valid), .iss_addr(a_iss_addr), .iss_ready(a_iss_ready),
      .wb_valid(a_wb_valid), .wb_addr(a_wb_addr),
      .rd_addr(a_rd_addr), .rd_busy(a_rd_busy),
      .pend(a_pend), .pend_cnt(a_pend_cnt), .err_wb(a_err_wb)
   );

   dec_scoreboard #(.ADDR_W(3), .RD_PORTS(3), .ZERO_REG(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush),
      .iss_valid(b_iss_valid), .iss_addr(b_iss_addr), .iss_ready(b_iss_ready),
      .wb_valid(b_wb_valid), .wb_addr(b_wb_addr),
      .rd_addr(b_rd_addr), .rd_busy(b_rd_busy),
      .pend(b_pend), .pend_cnt(b_pend_cnt), .err_wb(b_err_wb)
   );

   // ---------------- reference model (set of pending registers) ----------------
   function automatic bit m_ready(bit [31:0] p, int a, bit wv, int wa, bit fl);
      if (fl) return 1'b0;
      if (a == 0) return 1'b1;
      if (!p[a]) return 1'b1;
      return wv && (wa == a);
   endfunction

   function automatic bit m_busy(bit [31:0] p, int a, bit wv, int wa);
      if (a == 0) return 1'b0;
      return p[a] && !(wv && (wa == a));
   endfunction

   function automatic int m_count(bit [31:0] p);
      int n = 0;
      for (int i = 0; i < 32; i++) if (p[i]) n++;
      return n;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a;
      a_flush = 0; a_iss_valid = 0; a_iss_addr = 0; a_wb_valid = 0; a_wb_addr = 0; a_rd_addr = 0;
   endtask

   task automatic idle_b;
      b_flush = 0; b_iss_valid = 0; b_iss_addr = 0; b_wb_valid = 0; b_wb_addr = 0; b_rd_addr = 0;
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset;
      idle_a; idle_b;
      a_iss_valid = 1; a_iss_addr = 3; b_iss_valid = 1; b_iss_addr = 3;
      tick;
      idle_a; idle_b;
      a_rd_addr = {5'd3, 5'd3};
      #1;
      total++; if (a_pend !== 32'h8) begin bad++; $display("FAIL reset_pre a_pend: got %h want %h", a_pend, 32'h8); end
      total++; if (a_rd_busy !== 2'b11) begin bad++; $display("FAIL reset_pre a_rd_busy: got %b want 11", a_rd_busy); end
      total++; if (b_pend !== 8'h8) begin bad++; $display("FAIL reset_pre b_pend: got %h want 08", b_pend); end
      #1 rst_n = 0;
      #1;
      total++; if (a_pend !== 32'h0) begin bad++; $display("FAIL reset a_pend: got %h want 0", a_pend); end
      total++; if (a_pend_cnt !== 6'd0) begin bad++; $display("FAIL reset a_pend_cnt: got %0d want 0", a_pend_cnt); end
      total++; if (a_rd_busy !== 2'b00) begin bad++; $display("FAIL reset a_rd_busy: got %b want 00", a_rd_busy); end
      a_iss_addr = 3;
      #1;
      total++; if (a_iss_ready !== 1'b1) begin bad++; $display("FAIL reset a_iss_ready: got %b want 1", a_iss_ready); end
      total++; if (a_err_wb !== 1'b0) begin bad++; $display("FAIL reset a_err_wb: got %b want 0", a_err_wb); end
      total++; if (b_pend !== 8'h0 || b_pend_cnt !== 4'd0) begin bad++; $display("FAIL reset b_state: got %h/%0d want 00/0", b_pend, b_pend_cnt); end
      tick;
      #2 rst_n = 1;
      idle_a;
      tick;
   endtask

   task automatic test_issue_wb_a;
      idle_a;
      a_iss_valid = 1; a_iss_addr = 5; a_rd_addr = {5'd0, 5'd5};
      #1;
      total++; if (a_iss_ready !== 1'b1) begin bad++; $display("FAIL iss_a ready: got %b want 1", a_iss_ready); end
      total++; if (a_rd_busy[0] !== 1'b0) begin bad++; $display("FAIL iss_a busy_t: got %b want 0", a_rd_busy[0]); end
      tick;
      a_iss_valid = 0;
      #1;
      total++; if (a_pend !== 32'h20) begin bad++; $display("FAIL iss_a pend: got %h want 00000020", a_pend); end
      total++; if (a_pend_cnt !== 6'd1) begin bad++; $display("FAIL iss_a cnt: got %0d want 1", a_pend_cnt); end
      total++; if (a_rd_busy !== 2'b01) begin bad++; $display("FAIL iss_a busy: got %b want 01", a_rd_busy); end
      tick;
      tick;
      a_wb_valid = 1; a_wb_addr = 5;
      #1;
      total++; if (a_rd_busy[0] !== 1'b0) begin bad++; $display("FAIL wb_a busy_fwd: got %b want 0", a_rd_busy[0]); end
      total++; if (a_pend !== 32'h20) begin bad++; $display("FAIL wb_a pend_t: got %h want 00000020", a_pend); end
      tick;
      idle_a;
      #1;
      total++; if (a_pend !== 32'h0 || a_pend_cnt !== 6'd0) begin bad++; $display("FAIL wb_a cleared: got %h/%0d want 0/0", a_pend, a_pend_cnt); end
      total++; if (a_err_wb !== 1'b0) begin bad++; $display("FAIL wb_a err: got %b want 0", a_err_wb); end
   endtask

   task automatic test_waw_a;
      idle_a;
      a_iss_valid = 1; a_iss_addr = 7;
      tick;
      #1;
      total++; if (a_iss_ready !== 1'b0) begin bad++; $display("FAIL waw stall: got %b want 0", a_iss_ready); end
      tick;
      total++; if (a_pend !== 32'h80) begin bad++; $display("FAIL waw pend: got %h want 00000080", a_pend); end
      a_wb_valid = 1; a_wb_addr = 7;
      #1;
      total++; if (a_iss_ready !== 1'b1) begin bad++; $display("FAIL waw retire_ready: got %b want 1", a_iss_ready); end
      tick;
      total++; if (a_pend !== 32'h80 || a_pend_cnt !== 6'd1) begin bad++; $display("FAIL waw reissue: got %h/%0d want 80/1", a_pend, a_pend_cnt); end
      total++; if (a_err_wb !== 1'b0) begin bad++; $display("FAIL waw err: got %b want 0", a_err_wb); end
      idle_a;
      a_wb_valid = 1; a_wb_addr = 7;
      tick;
      idle_a;
      total++; if (a_pend !== 32'h0) begin bad++; $display("FAIL waw cleanup: got %h want 0", a_pend); end
   endtask

   task automatic test_zero_a;
      idle_a;
      a_iss_valid = 1; a_iss_addr = 0; a_rd_addr = 10'd0;
      #1;
      total++; if (a_iss_ready !== 1'b1) begin bad++; $display("FAIL zero ready: got %b want 1", a_iss_ready); end
      total++; if (a_rd_busy !== 2'b00) begin bad++; $display("FAIL zero busy: got %b want 00", a_rd_busy); end
      tick;
      total++; if (a_pend !== 32'h0) begin bad++; $display("FAIL zero pend: got %h want 0", a_pend); end
      idle_a;
      a_wb_valid = 1; a_wb_addr = 0;
      tick;
      idle_a;
      total++; if (a_err_wb !== 1'b0) begin bad++; $display("FAIL zero err: got %b want 0", a_err_wb); end
   endtask

   task automatic test_fill_a;
      idle_a;
      for (int i = 1; i < 32; i++) begin
         a_iss_valid = 1; a_iss_addr = 5'(i);
         tick;
      end
      a_iss_valid = 0;
      total++; if (a_pend !== 32'hFFFF_FFFE) begin bad++; $display("FAIL fill_a pend: got %h want fffffffe", a_pend); end
      total++; if (a_pend_cnt !== 6'd31) begin bad++; $display("FAIL fill_a cnt: got %0d want 31", a_pend_cnt); end
      a_flush = 1; a_iss_valid = 1; a_iss_addr = 3; a_wb_valid = 1; a_wb_addr = 3;
      #1;
      total++; if (a_iss_ready !== 1'b0) begin bad++; $display("FAIL flush_a ready: got %b want 0", a_iss_ready); end
      tick;
      idle_a;
      total++; if (a_pend !== 32'h0 || a_pend_cnt !== 6'd0) begin bad++; $display("FAIL flush_a clear: got %h/%0d want 0/0", a_pend, a_pend_cnt); end
      total++; if (a_err_wb !== 1'b0) begin bad++; $display("FAIL flush_a err: got %b want 0", a_err_wb); end
   endtask

   task automatic test_err_wb_a;
      idle_a;
      a_iss_valid = 1; a_iss_addr = 4;
      tick;
      idle_a;
      a_wb_valid = 1; a_wb_addr = 9;
      tick;
      idle_a;
      total++; if (a_err_wb !== 1'b1) begin bad++; $display("FAIL err_wb pulse: got %b want 1", a_err_wb); end
      total++; if (a_pend !== 32'h10) begin bad++; $display("FAIL err_wb pend: got %h want 00000010", a_pend); end
      tick;
      total++; if (a_err_wb !== 1'b0) begin bad++; $display("FAIL err_wb width: got %b want 0", a_err_wb); end
      a_wb_valid = 1; a_wb_addr = 4;
      tick;
      idle_a;
      total++; if (a_pend !== 32'h0) begin bad++; $display("FAIL err_wb cleanup: got %h want 0", a_pend); end
   endtask

   task automatic test_small_b;
      idle_b;
      b_iss_valid = 1; b_iss_addr = 5; b_rd_addr = {3'd0, 3'd5, 3'd5};
      tick;
      b_iss_valid = 0;
      #1;
      total++; if (b_pend !== 8'h20 || b_pend_cnt !== 4'd1) begin bad++; $display("FAIL iss_b pend: got %h/%0d want 20/1", b_pend, b_pend_cnt); end
      total++; if (b_rd_busy !== 3'b011) begin bad++; $display("FAIL iss_b busy: got %b want 011", b_rd_busy); end
      tick;
      tick;
      b_wb_valid = 1; b_wb_addr = 5;
      #1;
      total++; if (b_rd_busy !== 3'b000) begin bad++; $display("FAIL wb_b busy_fwd: got %b want 000", b_rd_busy); end
      tick;
      idle_b;
      total++; if (b_pend !== 8'h0) begin bad++; $display("FAIL wb_b cleared: got %h want 00", b_pend); end
      for (int i = 1; i < 8; i++) begin
         b_iss_valid = 1; b_iss_addr = 3'(i);
         tick;
      end
      b_iss_valid = 0;
      total++; if (b_pend !== 8'hFE || b_pend_cnt !== 4'd7) begin bad++; $display("FAIL fill_b: got %h/%0d want fe/7", b_pend, b_pend_cnt); end
      b_flush = 1; b_iss_valid = 1; b_iss_addr = 2;
      #1;
      total++; if (b_iss_ready !== 1'b0) begin bad++; $display("FAIL flush_b ready: got %b want 0", b_iss_ready); end
      tick;
      idle_b;
      total++; if (b_pend !== 8'h0 || b_pend_cnt !== 4'd0) begin bad++; $display("FAIL flush_b clear: got %h/%0d want 00/0", b_pend, b_pend_cnt); end
   endtask

   // ---------------- randomized traffic against the model ----------------
   task automatic test_random;
      bit [31:0] ma, mb;
      bit        fa, iva, wva, fb, ivb, wvb, ra, rb, ea, eb;
      int        ia, wa, ib, wb;
      int        qa[2];
      int        qb[3];
      logic [1:0] xa;
      logic [2:0] xb;
      #2 rst_n = 0;
      #1 rst_n = 1;
      ma = '0; mb = '0;
      for (int n = 0; n < 500; n++) begin
         fa  = ($urandom_range(19) == 0);
         iva = $urandom_range(1);  ia = $urandom_range(31);
         wva = $urandom_range(1);  wa = (ma != 0 && $urandom_range(2) != 0) ? $urandom_range(31) : $urandom_range(3);
         for (int k = 0; k < 2; k++) qa[k] = $urandom_range(31);
         fb  = ($urandom_range(19) == 0);
         ivb = $urandom_range(1);  ib = $urandom_range(7);
         wvb = $urandom_range(1);  wb = $urandom_range(7);
         for (int k = 0; k < 3; k++) qb[k] = $urandom_range(7);

         a_flush = fa; a_iss_valid = iva; a_iss_addr = 5'(ia); a_wb_valid = wva; a_wb_addr = 5'(wa);
         a_rd_addr = {5'(qa[1]), 5'(qa[0])};
         b_flush = fb; b_iss_valid = ivb; b_iss_addr = 3'(ib); b_wb_valid = wvb; b_wb_addr = 3'(wb);
         b_rd_addr = {3'(qb[2]), 3'(qb[1]), 3'(qb[0])};
         #1;
         ra = m_ready(ma, ia, wva, wa, fa);
         rb = m_ready(mb, ib, wvb, wb, fb);
         for (int k = 0; k < 2; k++) xa[k] = m_busy(ma, qa[k], wva, wa);
         for (int k = 0; k < 3; k++) xb[k] = m_busy(mb, qb[k], wvb, wb);
         total++; if (a_iss_ready !== ra) begin bad++; $display("FAIL rnd a_ready cyc %0d: got %b want %b", n, a_iss_ready, ra); end
         total++; if (a_rd_busy !== xa) begin bad++; $display("FAIL rnd a_busy cyc %0d: got %b want %b", n, a_rd_busy, xa); end
         total++; if (b_iss_ready !== rb) begin bad++; $display("FAIL rnd b_ready cyc %0d: got %b want %b", n, b_iss_ready, rb); end
         total++; if (b_rd_busy !== xb) begin bad++; $display("FAIL rnd b_busy cyc %0d: got %b want %b", n, b_rd_busy, xb); end

         ea = wva && !fa && (wa != 0) && !ma[wa];
         eb = wvb && !fb && (wb != 0) && !mb[wb];
         if (fa) ma = '0;
         else begin
            if (wva && wa != 0) ma[wa] = 1'b0;
            if (iva && ra && ia != 0) ma[ia] = 1'b1;
         end
         if (fb) mb = '0;
         else begin
            if (wvb && wb != 0) mb[wb] = 1'b0;
            if (ivb && rb && ib != 0) mb[ib] = 1'b1;
         end
         tick;
         total++; if (a_pend !== ma) begin bad++; $display("FAIL rnd a_pend cyc %0d: got %h want %h", n, a_pend, ma); end
         total++; if (a_pend_cnt !== 6'(m_count(ma))) begin bad++; $display("FAIL rnd a_cnt cyc %0d: got %0d want %0d", n, a_pend_cnt, m_count(ma)); end
         total++; if (a_err_wb !== ea) begin bad++; $display("FAIL rnd a_err cyc %0d: got %b want %b", n, a_err_wb, ea); end
         total++; if (b_pend !== mb[7:0]) begin bad++; $display("FAIL rnd b_pend cyc %0d: got %h want %h", n, b_pend, mb[7:0]); end
         total++; if (b_pend_cnt !== 4'(m_count(mb))) begin bad++; $display("FAIL rnd b_cnt cyc %0d: got %0d want %0d", n, b_pend_cnt, m_count(mb)); end
         total++; if (b_err_wb !== eb) begin bad++; $display("FAIL rnd b_err cyc %0d: got %b want %b", n, b_err_wb, eb); end
      end
      idle_a; idle_b;
   endtask

   initial begin
      rst_n = 0;
      idle_a; idle_b;
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      tick;
      test_reset;
      test_issue_wb_a;
      test_waw_a;
      test_zero_a;
      test_fill_a;
      test_err_wb_a;
      test_small_b;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
